// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Write-port controller for the register file. Two requesters share the
// file's single write port:
//   A - single-cycle writeback path (fixed priority over B)
//   B - multi-cycle / load return path (anti-starvation timer)
// After every reset the block sweeps zeros into every entry, because the
// register array itself has no reset. Writes to register 0 are granted
// but never reach the file, since register 0 reads as hardwired zero.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   a_req      A wants to write          a_addr / a_data  A's target / data
//   a_gnt      A accepted this cycle (combinational)
//   b_req      B wants to write          b_addr / b_data  B's target / data
//   b_gnt      B accepted this cycle (combinational)
//   init_busy  zero-fill sweep in progress
//   rf_we      registered write enable to the file
//   rf_rd      registered write address
//   rf_d       registered write data
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | zero-fill sweep, one entry per cycle, no grants
// ST_RUN  | normal arbitration between A and B
// ---------------------------------------------------------------------------
module regfile_wr_arbiter #(
  parameter int SECT    = 5,
  parameter int DW      = 32,
  parameter int MAXWAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_req,
  input  logic [SECT-1:0] a_addr,
  input  logic [DW-1:0]   a_data,
  output logic            a_gnt,
  input  logic            b_req,
  input  logic [SECT-1:0] b_addr,
  input  logic [DW-1:0]   b_data,
  output logic            b_gnt,
  output logic            init_busy,
  output logic            rf_we,
  output logic [SECT-1:0] rf_rd,
  output logic [DW-1:0]   rf_d
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [SECT-1:0] CNT_ONE   = SECT'(1);
  localparam logic [SECT-1:0] CNT_LAST  = '1;
  localparam logic [3:0]      WAIT_LOAD = 4'(MAXWAIT);
  localparam logic [3:0]      WAIT_ONE  = 4'd1;

  state_t          state, state_nxt;
  logic [SECT-1:0] cnt, cnt_nxt;
  // Cycles B may still be denied before it is forced through. Reloaded
  // whenever B is granted or withdraws; terminal count is zero.
  logic [3:0]      b_left, b_left_nxt;
  logic            force_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_INIT;
      cnt    <= '0;
      b_left <= WAIT_LOAD;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      b_left <= b_left_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    b_left_nxt = b_left;
    force_b    = 1'b0;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    case (state)
      ST_INIT: begin
        cnt_nxt    = cnt + CNT_ONE;
        b_left_nxt = WAIT_LOAD;
        if (cnt == CNT_LAST) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        force_b = b_req && (b_left == '0);
        a_gnt   = a_req && !force_b;
        b_gnt   = b_req && !a_gnt;
        if (b_req && !b_gnt) begin
          // Denial can only happen with time left; the guard keeps the
          // timer from wrapping should that ever change.
          if (b_left != '0) begin
            b_left_nxt = b_left - WAIT_ONE;
          end
        end else begin
          b_left_nxt = WAIT_LOAD;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign init_busy = (state == ST_INIT);

  // Write issue: one registered write per grant, one cycle after the grant.
  // Address and data hold their last value when nothing is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_d  <= '0;
    end else if (state == ST_INIT) begin
      rf_we <= 1'b1;
      rf_rd <= cnt;
      rf_d  <= '0;
    end else if (a_gnt) begin
      rf_we <= (a_addr != '0);
      rf_rd <= a_addr;
      rf_d  <= a_data;
    end else if (b_gnt) begin
      rf_we <= (b_addr != '0);
      rf_rd <= b_addr;
      rf_d  <= b_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

  localparam int SECT    = 5;
  localparam int DW      = 32;
  localparam int MAXWAIT = 4;
  localparam int NREG    = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            a_req = 1'b0;
  logic [SECT-1:0] a_addr = '0;
  logic [DW-1:0]   a_data = '0;
  logic            b_req = 1'b0;
  logic [SECT-1:0] b_addr = '0;
  logic [DW-1:0]   b_data = '0;
  logic            a_gnt, b_gnt, init_busy, rf_we;
  logic [SECT-1:0] rf_rd;
  logic [DW-1:0]   rf_d;

  regfile_wr_arbiter #(.SECT(SECT), .DW(DW), .MAXWAIT(MAXWAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
    .init_busy(init_busy), .rf_we(rf_we), .rf_rd(rf_rd), .rf_d(rf_d)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: sweep index, denied-cycle streak for B, expected
  // registered write outputs, and the two register-file images.
  bit          m_run;
  int          m_idx;
  int          m_streak;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_d;
  logic [31:0] model_file [NREG];
  logic [31:0] dut_file   [NREG];
  logic        exp_a, exp_b;
  logic        obs_a, obs_b, obs_we;
  logic [4:0]  obs_rd;
  logic [31:0] obs_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run    = 1'b0;
    m_idx    = 0;
    m_streak = 0;
    m_we     = 1'b0;
    m_rd     = '0;
    m_d      = '0;
  endtask

  // One clock cycle: inputs are already driven; check at the falling edge,
  // advance the model, then return just after the next rising edge.
  task automatic cycle();
    bit was_run;
    @(negedge clk);
    if (m_run) begin
      exp_a = a_req && !(b_req && (m_streak >= MAXWAIT));
      exp_b = b_req && !exp_a;
    end else begin
      exp_a = 1'b0;
      exp_b = 1'b0;
    end
    obs_a = a_gnt; obs_b = b_gnt; obs_we = rf_we; obs_rd = rf_rd; obs_d = rf_d;
    chk1("a_gnt", a_gnt, exp_a);
    chk1("b_gnt", b_gnt, exp_b);
    chk1("init_busy", init_busy, !m_run);
    chk1("rf_we", rf_we, m_we);
    chk("rf_rd", 32'(rf_rd), 32'(m_rd));
    chk("rf_d", rf_d, m_d);
    if (rf_we === 1'b1 && !$isunknown(rf_rd)) dut_file[rf_rd] = rf_d;
    if (m_we) model_file[m_rd] = m_d;
    was_run = m_run;
    if (!m_run) begin
      m_we = 1'b1; m_rd = 5'(m_idx); m_d = '0;
      m_idx++;
      if (m_idx == NREG) m_run = 1'b1;
    end else if (exp_a) begin
      m_we = (a_addr != '0); m_rd = a_addr; m_d = a_data;
    end else if (exp_b) begin
      m_we = (b_addr != '0); m_rd = b_addr; m_d = b_data;
    end else begin
      m_we = 1'b0;
    end
    if (was_run && b_req && !exp_b) begin
      if (m_streak < MAXWAIT) m_streak++;
    end else begin
      m_streak = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic compare_files(input string tag);
    for (int i = 0; i < NREG; i++)
      chk($sformatf("%s[%0d]", tag, i), dut_file[i], model_file[i]);
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      model_file[i] = '0;
      dut_file[i]   = '0;
    end
    model_reset();

    // Reset values while reset is held
    #12;
    chk1("rst_we", rf_we, 1'b0);
    chk1("rst_busy", init_busy, 1'b1);
    chk1("rst_agnt", a_gnt, 1'b0);
    chk1("rst_bgnt", b_gnt, 1'b0);
    chk("rst_rd", 32'(rf_rd), 0);
    chk("rst_d", rf_d, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Sweep: reset-state cycle, 32 sweep writes, then one idle cycle
    repeat (NREG + 2) cycle();
    chk1("sweep_idle_we", obs_we, 1'b0);

    // A alone
    a_req = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    cycle();
    chk1("t2_agnt", obs_a, 1'b1);
    a_req = 1'b0;
    cycle();
    chk1("t2_we", obs_we, 1'b1);
    chk("t2_rd", 32'(obs_rd), 5);
    chk("t2_d", obs_d, 32'hDEADBEEF);

    // Continuous A and B: 4 A grants then 1 B grant
    a_req = 1'b1; a_addr = 5'd3; a_data = 32'h11;
    b_req = 1'b1; b_addr = 5'd7; b_data = 32'h22;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk1("t3_bgnt", obs_b, (i % 5) == 4);
    end
    a_req = 1'b0; b_req = 1'b0;
    cycle();
    chk("t3_last_rd", 32'(obs_rd), 7);

    // B alone to register 0
    b_req = 1'b1; b_addr = 5'd0; b_data = 32'hFFFFFFFF;
    cycle();
    chk1("t4_bgnt", obs_b, 1'b1);
    b_req = 1'b0;
    cycle();
    chk1("t4_we", obs_we, 1'b0);

    // Same address from both: A first, B's data ends up in the file
    a_req = 1'b1; a_addr = 5'd9; a_data = 32'hA;
    b_req = 1'b1; b_addr = 5'd9; b_data = 32'hB;
    cycle();
    chk1("t5_agnt", obs_a, 1'b1);
    chk1("t5_bgnt0", obs_b, 1'b0);
    a_req = 1'b0;
    cycle();
    chk1("t5_bgnt1", obs_b, 1'b1);
    chk("t5_d_a", obs_d, 32'hA);
    b_req = 1'b0;
    cycle();
    chk("t5_d_b", obs_d, 32'hB);
    cycle();
    chk("t5_file9", dut_file[9], 32'hB);

    // Randomized traffic with hold-until-grant and occasional B withdrawal
    a_req = 1'b0; b_req = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!a_req) begin
        a_req = ($urandom_range(0, 3) != 0);
        a_addr = 5'($urandom); a_data = $urandom;
      end
      if (!b_req) begin
        b_req = ($urandom_range(0, 2) != 0);
        b_addr = 5'($urandom); b_data = $urandom;
      end else if ($urandom_range(0, 11) == 0) begin
        b_req = 1'b0;
      end
      cycle();
      if (exp_a) a_req = 1'b0;
      if (exp_b) b_req = 1'b0;
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) cycle();
    compare_files("rand_file");

    // Reset while a granted write is pending
    a_req = 1'b1; a_addr = 5'd12; a_data = 32'h12345678;
    cycle();
    chk1("t7_agnt", obs_a, 1'b1);
    chk1("t7_we_pre", rf_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("t7_we_rst", rf_we, 1'b0);
    chk1("t7_busy_rst", init_busy, 1'b1);
    chk1("t7_agnt_rst", a_gnt, 1'b0);
    model_reset();
    #1;
    rst_n = 1'b1;
    repeat (NREG + 1) cycle();
    chk1("t7_first_grant", obs_a, 1'b1);
    a_req = 1'b0;
    cycle();
    chk("t7_rd", 32'(obs_rd), 12);
    repeat (2) cycle();
    compare_files("final_file");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
